// File: rtl/apb_link_if.sv
// Host-side bus bundle for apb_link: request inputs plus the
// master/slave phase signals the link exposes.
interface apb_link_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              transfer;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PDATA;
    logic              PENABLE;
    logic [ADDR_W-1:0] PRWADDR;
    logic [DATA_W-1:0] PRWDATA;
    logic [DATA_W-1:0] PRDATA1;
    logic              PREADY;

    modport master (
        output PSEL, transfer, PWRITE, PADDR, PDATA,
        input  PENABLE, PRWADDR, PRWDATA, PRDATA1, PREADY
    );

    modport slave (
        input  PSEL, transfer, PWRITE, PADDR, PDATA,
        output PENABLE, PRWADDR, PRWDATA, PRDATA1, PREADY
    );
endinterface

// File: rtl/apb_link.sv
// APB-style link: IDLE/SETUP/ACCESS master FSM feeding a
// zero-wait-state word-addressed slave register file.
module apb_link #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apb_link_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic              penable;
    logic [ADDR_W-1:0] rw_addr;
    logic [DATA_W-1:0] rw_data;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              start;
    logic              ready;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  idx;

    assign start = bus.PSEL & bus.transfer;
    assign ready = bus.PSEL & penable;
    assign wr_en = ready & bus.PWRITE;
    assign rd_en = ready & ~bus.PWRITE;

    // Low address bits select a byte within the word; high bits alias.
    assign idx = rw_addr[IDX_W+1:2];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            penable <= 1'b0;
            rw_addr <= '0;
            rw_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    penable <= 1'b0;
                    if (start) begin
                        state   <= SETUP;
                        rw_addr <= bus.PADDR;
                        rw_data <= bus.PDATA;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (!bus.PSEL) begin
                        state   <= IDLE;
                        penable <= 1'b0;
                    end else if (ready) begin
                        penable <= 1'b0;
                        if (start) begin
                            state   <= SETUP;
                            rw_addr <= bus.PADDR;
                            rw_data <= bus.PDATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    penable <= 1'b0;
                end
            endcase
        end
    end

    // Reset also wipes storage, so a write landing on a reset edge is lost.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= rw_data;
        end
    end

    assign bus.PENABLE = penable;
    assign bus.PRWADDR = rw_addr;
    assign bus.PRWDATA = rw_data;
    assign bus.PREADY  = ready;
    assign bus.PRDATA1 = rd_en ? mem[idx] : '0;
endmodule

// File: tb/tb_apb_link.sv
// Self-checking bench for apb_link: directed scenarios plus random
// transfers checked against a word-array memory model.
module tb_apb_link;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem_m [DEPTH];

    apb_link_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_link #(
        .ADDR_W(32),
        .DATA_W(32),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .PCLK(clk),
        .PRESET(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // One complete host transfer; returns what was observed on the bus.
    task automatic do_xfer(
        input  logic        w,
        input  logic [31:0] addr,
        input  logic [31:0] data,
        output logic [31:0] rd,
        output logic [31:0] obs_addr,
        output logic [31:0] setup_rd,
        output logic        setup_rdy,
        output int          lat,
        output bit          ok
    );
        rd = '0;
        obs_addr = '0;
        ok = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.PSEL = 1'b1;
        bus.transfer = 1'b1;
        bus.PWRITE = w;
        bus.PADDR = addr;
        bus.PDATA = data;
        @(posedge clk);
        @(negedge clk);
        bus.transfer = 1'b0;
        #1;
        setup_rd = bus.PRDATA1;
        setup_rdy = bus.PREADY;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (bus.PENABLE === 1'b1 && bus.PREADY === 1'b1) begin
                ok = 1'b1;
                rd = bus.PRDATA1;
                obs_addr = bus.PRWADDR;
            end else begin
                lat++;
                @(negedge clk);
                #1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.PSEL = 1'b0;
        bus.transfer = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, oa, srd;
        logic        srdy;
        int          lat;
        bit          ok;
        @(negedge clk);
        rst = 1'b1;
        bus.PSEL = 1'b0;
        bus.transfer = 1'b0;
        bus.PWRITE = 1'b0;
        bus.PADDR = '0;
        bus.PDATA = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b0 || bus.PREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: penable=%b pready=%b want 0 0",
                     bus.PENABLE, bus.PREADY);
        end
        checks++;
        if (bus.PRWADDR !== 32'h0 || bus.PRWDATA !== 32'h0
            || bus.PRDATA1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: addr=%h data=%h rdata=%h want 0",
                     bus.PRWADDR, bus.PRWDATA, bus.PRDATA1);
        end
        rst = 1'b0;
        clear_model();
        do_xfer(1'b0, 32'hC, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: ok=%0d rdata=%h want 1 0", ok, rd);
        end
    endtask

    task automatic test_stream();
        logic exp_en [4];
        exp_en = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        bus.PSEL = 1'b1;
        bus.transfer = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR = 32'h0;
        bus.PDATA = 32'h0000_0309;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (bus.PENABLE !== exp_en[i]) begin
                failures++;
                $display("FAIL stream_penable[%0d]: got %b want %b",
                         i, bus.PENABLE, exp_en[i]);
            end
        end
        bus.PSEL = 1'b0;
        bus.transfer = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b0 || bus.PRWADDR !== 32'h0
            || bus.PRWDATA !== 32'h309) begin
            failures++;
            $display("FAIL stream_end: en=%b addr=%h data=%h want 0 0 309",
                     bus.PENABLE, bus.PRWADDR, bus.PRWDATA);
        end
        mem_m[0] = 32'h0000_0309;
    endtask

    task automatic test_seq_writes();
        logic [31:0] vals [3];
        logic [31:0] rd, oa, srd;
        logic        srdy;
        int          lat;
        bit          ok;
        vals = '{32'h2112_2023, 32'h5A48_5552, 32'h4449_4D41};
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(4 * (i + 1));
            do_xfer(1'b1, a, vals[i], rd, oa, srd, srdy, lat, ok);
            mem_m[idx_of(a)] = vals[i];
            checks++;
            if (!ok || lat != 1 || oa !== a) begin
                failures++;
                $display("FAIL seq_write[%0d]: ok=%0d lat=%0d addr=%h want 1 1 %h",
                         i, ok, lat, oa, a);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_readback();
        logic [31:0] rd, oa, srd;
        logic        srdy;
        int          lat;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            do_xfer(1'b0, a, 32'hFFFF_FFFF, rd, oa, srd, srdy, lat, ok);
            checks++;
            if (!ok || lat != 1 || rd !== mem_m[idx_of(a)]) begin
                failures++;
                $display("FAIL readback[%0d]: ok=%0d lat=%0d rdata=%h want %h",
                         i, ok, lat, rd, mem_m[idx_of(a)]);
            end
            checks++;
            if (srd !== 32'h0 || srdy !== 1'b0) begin
                failures++;
                $display("FAIL readback_setup[%0d]: rdata=%h ready=%b want 0 0",
                         i, srd, srdy);
            end
        end
        #1;
        checks++;
        if (bus.PRDATA1 !== 32'h0 || bus.PREADY !== 1'b0) begin
            failures++;
            $display("FAIL readback_idle: rdata=%h ready=%b want 0 0",
                     bus.PRDATA1, bus.PREADY);
        end
    endtask

    task automatic test_no_transfer();
        logic [31:0] held, rd, oa, srd;
        logic        srdy;
        int          lat;
        bit          ok;
        held = bus.PRWADDR;
        @(negedge clk);
        bus.PSEL = 1'b1;
        bus.transfer = 1'b0;
        bus.PWRITE = 1'b1;
        bus.PADDR = 32'h8;
        bus.PDATA = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.PENABLE !== 1'b0 || bus.PRWADDR !== held) begin
                failures++;
                $display("FAIL no_transfer[%0d]: en=%b addr=%h want 0 %h",
                         i, bus.PENABLE, bus.PRWADDR, held);
            end
        end
        bus.PSEL = 1'b0;
        do_xfer(1'b0, 32'h8, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== mem_m[2]) begin
            failures++;
            $display("FAIL no_transfer_mem: rdata=%h want %h", rd, mem_m[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, oa, srd;
        logic        srdy;
        int          lat;
        bit          ok;
        @(negedge clk);
        bus.PSEL = 1'b1;
        bus.transfer = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR = 32'h4;
        bus.PDATA = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.transfer = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_access: en=%b want 1", bus.PENABLE);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b0 || bus.PRWADDR !== 32'h0
            || bus.PRWDATA !== 32'h0 || bus.PRDATA1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_out: en=%b addr=%h data=%h rd=%h want 0",
                     bus.PENABLE, bus.PRWADDR, bus.PRWDATA, bus.PRDATA1);
        end
        rst = 1'b0;
        bus.PSEL = 1'b0;
        clear_model();
        do_xfer(1'b0, 32'h4, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_mem: rdata=%h want 0", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, oa, srd, keep;
        logic        srdy;
        int          lat;
        bit          ok;
        keep = $urandom;
        do_xfer(1'b1, 32'h8, keep, rd, oa, srd, srdy, lat, ok);
        mem_m[2] = keep;
        @(negedge clk);
        bus.PSEL = 1'b1;
        bus.transfer = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR = 32'h8;
        bus.PDATA = ~keep;
        @(posedge clk);
        @(negedge clk);
        bus.PSEL = 1'b0;
        bus.transfer = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b1 || bus.PREADY !== 1'b0) begin
            failures++;
            $display("FAIL abort_access: en=%b ready=%b want 1 0",
                     bus.PENABLE, bus.PREADY);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.PENABLE !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: en=%b want 0", bus.PENABLE);
        end
        do_xfer(1'b0, 32'h8, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== mem_m[2]) begin
            failures++;
            $display("FAIL abort_mem: rdata=%h want %h", rd, mem_m[2]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, oa, srd, v;
        logic        srdy;
        int          lat;
        bit          ok;
        do_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, rd, oa, srd, srdy, lat, ok);
        mem_m[idx_of(32'h40)] = 32'hDEAD_BEEF;
        do_xfer(1'b0, 32'h0, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wrap_0x40: rdata=%h want deadbeef", rd);
        end
        v = $urandom;
        do_xfer(1'b1, 32'h7, v, rd, oa, srd, srdy, lat, ok);
        mem_m[idx_of(32'h7)] = v;
        do_xfer(1'b0, 32'h4, 32'h0, rd, oa, srd, srdy, lat, ok);
        checks++;
        if (!ok || rd !== v) begin
            failures++;
            $display("FAIL alias_0x7: rdata=%h want %h", rd, v);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, oa, srd, a, d;
        logic        srdy, w;
        int          lat;
        bit          ok;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            do_xfer(w, a, d, rd, oa, srd, srdy, lat, ok);
            checks++;
            if (!ok || lat != 1 || oa !== a) begin
                failures++;
                $display("FAIL rand_xfer[%0d]: ok=%0d lat=%0d addr=%h want %h",
                         n, ok, lat, oa, a);
            end
            if (w) begin
                mem_m[idx_of(a)] = d;
            end else begin
                checks++;
                if (rd !== mem_m[idx_of(a)]) begin
                    failures++;
                    $display("FAIL rand_read[%0d]: addr=%h rdata=%h want %h",
                             n, a, rd, mem_m[idx_of(a)]);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'(4 * i);
            do_xfer(1'b0, a, 32'h0, rd, oa, srd, srdy, lat, ok);
            checks++;
            if (!ok || rd !== mem_m[i]) begin
                failures++;
                $display("FAIL rand_sweep[%0d]: rdata=%h want %h",
                         i, rd, mem_m[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.PSEL = 1'b0;
        bus.transfer = 1'b0;
        bus.PWRITE = 1'b0;
        bus.PADDR = '0;
        bus.PDATA = '0;
        clear_model();
        test_reset();
        test_stream();
        test_seq_writes();
        test_readback();
        test_no_transfer();
        test_reset_mid();
        test_abort();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
